eca_engine: RTL



---
 rtl/eca_pkg.sv | 20 ++
 rtl/eca_next_gen.sv | 47 ++++
 rtl/eca_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular automaton engine.
package eca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_STEP   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Encoding 2'd3 is reserved and treated like BND_ZERO by the datapath.
  typedef enum logic [1:0] {
    BND_ZERO = 2'd0,
    BND_ONE  = 2'd1,
    BND_WRAP = 2'd2
  } bnd_t;

  localparam logic [7:0] RULE_110 = 8'd110;

endpackage

// File: rtl/eca_next_gen.sv
// Combinational next-generation function for an elementary CA of WIDTH cells.
// Cell i uses L = cell i+1, C = cell i, R = cell i-1; edges come from the boundary mode.
import eca_pkg::*;

module eca_next_gen #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_cells,
  input  logic [7:0]       i_rule,
  input  logic [1:0]       i_boundary,
  output logic [WIDTH-1:0] o_next
);

  logic             w_left_edge;
  logic             w_right_edge;
  logic [WIDTH+1:0] w_ext;

  always_comb begin
    w_left_edge  = 1'b0;
    w_right_edge = 1'b0;
    case (i_boundary)
      BND_ONE: begin
        w_left_edge  = 1'b1;
        w_right_edge = 1'b1;
      end
      BND_WRAP: begin
        w_left_edge  = i_cells[0];
        w_right_edge = i_cells[WIDTH-1];
      end
      default: begin
        w_left_edge  = 1'b0;
        w_right_edge = 1'b0;
      end
    endcase
  end

  // Padded vector: w_ext[i+2:i] is the {L,C,R} neighbourhood of cell i.
  assign w_ext = {w_left_edge, i_cells, w_right_edge};

  always_comb begin
    o_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_next[i] = i_rule[w_ext[i+2 -: 3]];
    end
  end

endmodule

// File: rtl/eca_engine.sv
// Elementary CA engine: CHUNK-wide seed load, N generations, each emitted as
// WIDTH/CHUNK MSB-first beats on a valid/ready stream.
import eca_pkg::*;

module eca_engine #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cfg_rule,
  input  logic [1:0]       cfg_boundary,
  input  logic             load_valid,
  input  logic [CHUNK-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
  input  logic [GEN_W-1:0] gen_count,
  output logic             out_valid,
  output logic [CHUNK-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int BEATS = WIDTH / CHUNK;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Stream handshake: a beat transfers on any clock edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low, out_data
  // and out_valid hold (the cell register and beat index do not move).
  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_cells;
  logic [BW-1:0]    r_beat;
  logic [GEN_W-1:0] r_gen;
  logic [GEN_W-1:0] r_n;
  logic [7:0]       r_rule;
  logic [1:0]       r_bnd;
  logic [WIDTH-1:0] w_next_cells;
  logic [WIDTH-1:0] w_shifted;
  logic             w_out_hs;
  logic             w_frame_end;

  eca_next_gen #(.WIDTH(WIDTH)) u_next_gen (
    .i_cells    (r_cells),
    .i_rule     (r_rule),
    .i_boundary (r_bnd),
    .o_next     (w_next_cells)
  );

  assign w_out_hs    = (r_state == ST_STREAM) && out_ready;
  assign w_frame_end = w_out_hs && (r_beat == LAST_BEAT);
  assign w_shifted   = r_cells << (CHUNK * r_beat);
  assign dbg_state   = r_state;

  always_comb begin
    w_next_state = r_state;
    load_ready   = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
        if (start) w_next_state = ST_STREAM;
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        out_data  = w_shifted[WIDTH-1 -: CHUNK];
        if (w_frame_end) w_next_state = (r_gen == r_n) ? ST_DONE : ST_STEP;
      end
      ST_STEP: w_next_state = ST_STREAM;
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cells <= '0;
      r_beat  <= '0;
      r_gen   <= '0;
      r_n     <= '0;
      r_rule  <= RULE_110;
      r_bnd   <= BND_ZERO;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (load_valid) r_cells <= {r_cells[WIDTH-CHUNK-1:0], load_data};
          if (start) begin
            r_rule <= cfg_rule;
            r_bnd  <= cfg_boundary;
            r_n    <= gen_count;
            r_beat <= '0;
            r_gen  <= '0;
          end
        end
        ST_STREAM: begin
          if (w_out_hs) r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
        end
        ST_STEP: begin
          r_cells <= w_next_cells;
          r_gen   <= r_gen + 1'b1;
          r_beat  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
